masked_xor_arbiter: RTL and testbench
=====================================

Name: masked_xor_arbiter

Overview:
- Shares one pipelined, share-wise masked XOR lane (d shares x W bits) between two requesters, e.g. AddRoundKey data path and key-schedule word updates.
- Provides a round-robin grant with bounded burst length, valid/ready handshakes on both inputs and the output, and a single output register stage.
- Sits between the requester sequencers and the consumer of XOR results.
- The XOR is linear, so no randomness is consumed; the lane is instantiated so that synthesis cannot merge shares.

Parameters:
- d, 2, number of shares (>=2).
- W, 32, bits per share.
- BURST, 4, maximum consecutive grants to one requester while the other is waiting (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- syn_rst  in  1  synchronous, active-high reset.
- in0_valid  in  1  requester 0 operand pair valid.
- in0_ready  out  1  requester 0 transfer accepted this cycle.
- in0_a  in  d*W  requester 0 operand A, shared bus layout (share i at bits [i*W +: W]).
- in0_b  in  d*W  requester 0 operand B, same layout.
- in1_valid  in  1  requester 1 operand pair valid.
- in1_ready  out  1  requester 1 transfer accepted this cycle.
- in1_a  in  d*W  requester 1 operand A.
- in1_b  in  d*W  requester 1 operand B.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  d*W  registered result a^b, computed share-wise.
- out_src  out  1  index of the requester that produced out_data.

Behaviour:
- Clock and reset: single clock clk; syn_rst is synchronous and active-high.
- Reset values: out_valid=0, out_src=0, out_data=0, in0_ready=in1_ready=0 during the reset cycle, priority pointer=0, burst counter=0.
- Pipeline:
  - A slot is free when out_valid=0 or out_ready=1 (register empty or draining this cycle).
  - Grant is issued only when the slot is free.
  - inN_ready is combinational: grant to N and slot free. At most one ready is high per cycle.
- Latency: a transfer accepted in cycle t appears with out_valid=1 in cycle t+1. Full throughput is 1 result per cycle with no bubbles while out_ready=1.
- Hold: if out_valid=1 and out_ready=0, then out_data and out_src are held stable and both readies are 0.
- Arbitration (state: ptr, cnt):
  - Only one valid: that requester is granted regardless of ptr.
  - Both valid: the requester given by ptr is granted.
  - On each accepted transfer from N:
    - If N==ptr, cnt increments. When cnt+1==BURST and the other requester is valid, ptr flips and cnt is cleared.
    - If N!=ptr (the other requester was idle), ptr is set to N and cnt=1.
  - A cycle with no transfer leaves ptr and cnt unchanged.
  - cnt saturates at BURST-1 while the other requester is idle, so it never wraps.
- Fairness: with both requesters continuously valid and out_ready=1, the grant pattern is BURST transfers from one, then BURST from the other.
- Datapath:
  - out_data share i = a share i XOR b share i, one bin_XOR instance per share.
  - There is no cross-share logic. The operand mux selects whole buses only, with a one-hot select derived from the grant.
- Handshake rules:
  - Requesters must hold valid and operands stable until ready.
  - If a requester drops valid without a handshake, the block only re-arbitrates; no error is signalled.
- Reset mid-operation: a pending result is discarded (out_valid=0 in the next cycle), and ptr and cnt return to their reset values.

Optional Feature:
- Macro: MXA_CLEAR_IDLE_EN.
- When defined:
  - With no grant, the operand mux outputs all-zero buses, not the last-selected requester's buses.
  - out_data is cleared to 0 in the cycle after the result is consumed and no new transfer occurs.
  - This limits transition leakage between unrelated sharings.
- When undefined:
  - The mux defaults to requester 0's buses.
  - out_data keeps its last value while out_valid=0.
- Handshake timing and arbitration are identical in both builds.

Test Plan:
- Single requester: d=2, W=32, in0_a={32'h0F0F0F0F,32'h12345678}, in0_b={32'hFFFFFFFF,32'h00000000}, out_ready=1.
  -> Next cycle: out_valid=1, out_data={32'hF0F0F0F0,32'h12345678}, out_src=0. Unshared value is 0x E2C4A688 check: share0^share1 of output equals that of a^b.
- Both requesters constantly valid, BURST=4, out_ready=1 for 16 cycles.
  -> out_src sequence 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1.
- Backpressure: out_ready=0 for 3 cycles with a result pending.
  -> out_data and out_src stable, in0_ready=in1_ready=0.
  -> When out_ready rises: a new transfer is accepted in the same cycle and the next result appears the following cycle.
- Idle switch: requester 1 alone for 2 transfers, then requester 0 alone.
  -> Requester 0 is granted immediately; ptr=0 and cnt=1 afterwards.
- syn_rst asserted while out_valid=1 and requester 1 mid-burst (cnt=2).
  -> Next cycle: out_valid=0 and ptr=0. With both requesters valid, the first grant goes to requester 0.
- With MXA_CLEAR_IDLE_EN: result consumed, no valid inputs.
  -> out_data==0 the following cycle. Without the macro, out_data retains its previous value.

Source files
------------

// File: rtl/masked_xor_arbiter.sv
// masked_xor_arbiter: round-robin shared masked XOR lane (d shares x W bits) with one output register.
// Build option MXA_CLEAR_IDLE_EN zeroes the idle operand mux and clears a consumed result.
module masked_xor_arbiter #(
   parameter int d     = 2,
   parameter int W     = 32,
   parameter int BURST = 4
) (
   input  logic           clk,
   input  logic           syn_rst,
   input  logic           in0_valid,
   output logic           in0_ready,
   input  logic [d*W-1:0] in0_a,
   input  logic [d*W-1:0] in0_b,
   input  logic           in1_valid,
   output logic           in1_ready,
   input  logic [d*W-1:0] in1_a,
   input  logic [d*W-1:0] in1_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [d*W-1:0] out_data,
   output logic           out_src
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);
   localparam logic [CW-1:0] CNT_ONE = (BURST > 1) ? CW'(1) : CW'(0);

   logic           ptr_reg;
   logic           ptr_next;
   logic [CW-1:0]  cnt_reg;
   logic [CW-1:0]  cnt_next;
   logic           out_valid_reg;
   logic           out_src_reg;
   logic [d*W-1:0] out_data_reg;

   logic           slot_free;
   logic           grant0;
   logic           grant1;
   logic           take0;
   logic           take1;
   logic           xfer;
   logic           other_valid;
   logic [1:0]     sel;
   logic [d*W-1:0] mux_a;
   logic [d*W-1:0] mux_b;
   logic [d*W-1:0] xor_y;

   assign slot_free = ~out_valid_reg | out_ready;

   // A lone requester always wins; with both valid the pointer decides.
   assign grant0 = in0_valid & (~in1_valid | ~ptr_reg);
   assign grant1 = in1_valid & (~in0_valid | ptr_reg);

   assign take0 = grant0 & slot_free & ~syn_rst;
   assign take1 = grant1 & slot_free & ~syn_rst;
   assign xfer  = take0 | take1;

   assign in0_ready = take0;
   assign in1_ready = take1;

`ifdef MXA_CLEAR_IDLE_EN
   assign sel = {take1, take0};
`else
   assign sel = {take1, ~take1};
`endif

   // Whole-bus AND-OR mux: shares are never recombined here.
   assign mux_a = ({(d*W){sel[0]}} & in0_a) | ({(d*W){sel[1]}} & in1_a);
   assign mux_b = ({(d*W){sel[0]}} & in0_b) | ({(d*W){sel[1]}} & in1_b);

   generate
      for (genvar gi = 0; gi < d; gi++) begin : g_share
         (* keep_hierarchy = "yes" *)
         bin_XOR #(.W(W)) u_xor (
            .a (mux_a[gi*W +: W]),
            .b (mux_b[gi*W +: W]),
            .y (xor_y[gi*W +: W])
         );
      end
   endgenerate

   assign other_valid = take1 ? in0_valid : in1_valid;

   always_comb begin
      ptr_next = ptr_reg;
      cnt_next = cnt_reg;
      if (xfer) begin
         if (take1 == ptr_reg) begin
            // Burst exhausted: hand over only if the other side is waiting, else saturate.
            if (cnt_reg == CNT_MAX) begin
               if (other_valid) begin
                  ptr_next = ~ptr_reg;
                  cnt_next = '0;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end else begin
            ptr_next = take1;
            cnt_next = CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (syn_rst) begin
         ptr_reg       <= 1'b0;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_src_reg   <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         ptr_reg <= ptr_next;
         cnt_reg <= cnt_next;
         if (xfer) begin
            out_valid_reg <= 1'b1;
            out_src_reg   <= take1;
            out_data_reg  <= xor_y;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
`ifdef MXA_CLEAR_IDLE_EN
            out_data_reg  <= '0;
`endif
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_src   = out_src_reg;
   assign out_data  = out_data_reg;

endmodule

// One share of the lane; kept as its own instance so shares stay physically separate.
module bin_XOR #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   assign y = a ^ b;
endmodule

// File: tb/tb_masked_xor_arbiter.sv
// Testbench for masked_xor_arbiter: directed vector table, fairness sequence, randomized model check.
module tb_masked_xor_arbiter;

   localparam int D     = 2;
   localparam int WB    = 32;
   localparam int BURST = 4;
   localparam int DW    = D * WB;
`ifdef MXA_CLEAR_IDLE_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   localparam logic [DW-1:0] A0 = {32'h0F0F0F0F, 32'h12345678};
   localparam logic [DW-1:0] B0 = {32'hFFFFFFFF, 32'h00000000};
   localparam logic [DW-1:0] X0 = {32'hF0F0F0F0, 32'h12345678};
   localparam logic [DW-1:0] A1 = {32'hDEADBEEF, 32'h01020304};
   localparam logic [DW-1:0] B1 = {32'h11111111, 32'h10203040};
   localparam logic [DW-1:0] X1 = {32'hCFBCAFFE, 32'h11223344};
   localparam logic [DW-1:0] A2 = {32'hAAAAAAAA, 32'h55555555};
   localparam logic [DW-1:0] B2 = {32'h0000FFFF, 32'hFFFF0000};
   localparam logic [DW-1:0] X2 = {32'hAAAA5555, 32'hAAAA5555};

   logic          clk = 1'b0;
   logic          syn_rst;
   logic          in0_valid, in0_ready, in1_valid, in1_ready;
   logic          out_valid, out_ready, out_src;
   logic [DW-1:0] in0_a, in0_b, in1_a, in1_b, out_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   masked_xor_arbiter #(.d(D), .W(WB), .BURST(BURST)) dut (
      .clk       (clk),
      .syn_rst   (syn_rst),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_a     (in0_a),
      .in0_b     (in0_b),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_a     (in1_a),
      .in1_b     (in1_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   typedef struct {
      logic          rst;
      logic          v0;
      logic          alt0;
      logic          v1;
      logic          ordy;
      logic          e_r0;
      logic          e_r1;
      logic          e_ov;
      logic          e_src;
      logic [DW-1:0] e_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, v0, alt0, v1, ordy, e_r0, e_r1, e_ov, e_src,
                               input logic [DW-1:0] e_data);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.alt0 = alt0; v.v1 = v1; v.ordy = ordy;
      v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov; v.e_src = e_src; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, v0, v1, ordy, input logic [DW-1:0] a0, b0, a1, b1);
      syn_rst   = rst;
      in0_valid = v0;
      in1_valid = v1;
      out_ready = ordy;
      in0_a = a0; in0_b = b0; in1_a = a1; in1_b = b1;
   endtask

   // Reference state: result register contents plus who owns the current burst and its length.
   bit            m_ov;
   bit            m_src;
   logic [DW-1:0] m_data;
   int            m_owner;
   int            m_run;

   function automatic logic [DW-1:0] share_xor(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      for (int s = 0; s < D; s++) r[s*WB +: WB] = a[s*WB +: WB] ^ b[s*WB +: WB];
      return r;
   endfunction

   initial begin
      logic [DW-1:0] ed;
      logic          acc0, acc1;
      int            g;
      int            ntx;

      ed = CLR ? '0 : X0;
      // rst v0 alt0 v1 ordy | r0 r1 ov src data
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, '0));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, '0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 0, X2));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 1, X1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 1, X1));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 1, 0, X0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 1, 1, X1));
      vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 1, 1, X1));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, '0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 1, 0, X0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, ed));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ed));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].ordy,
               vecs[i].alt0 ? A2 : A0, vecs[i].alt0 ? B2 : B0, A1, B1);
         #1;
         chk($sformatf("vec%0d in0_ready", i), DW'(in0_ready), DW'(vecs[i].e_r0));
         chk($sformatf("vec%0d in1_ready", i), DW'(in1_ready), DW'(vecs[i].e_r1));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
         chk($sformatf("vec%0d out_src", i), DW'(out_src), DW'(vecs[i].e_src));
         chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_data);
         if (i == 2) chk("unshared_result", DW'(out_data[63:32] ^ out_data[31:0]), DW'(32'hE2C4A688));
         $display("vec %0d: ov=%b src=%b data=%h", i, out_valid, out_src, out_data);
         @(negedge clk);
      end

      // Fairness: both requesters always valid, consumer always ready.
      drive(1, 1, 1, 1, A0, B0, A1, B1);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 1, 1, A0, B0, A1, B1);
         #1;
         chk($sformatf("fair%0d in0_ready", i), DW'(in0_ready), DW'(((i / BURST) % 2) == 0));
         @(posedge clk);
         #1;
         chk($sformatf("fair%0d out_src", i), DW'(out_src), DW'((i / BURST) % 2));
         chk($sformatf("fair%0d out_data", i), out_data, (((i / BURST) % 2) == 0) ? X0 : X1);
         $display("fair %0d: src=%b", i, out_src);
         @(negedge clk);
      end

      // Randomized traffic against the reference model.
      drive(1, 0, 0, 1, '0, '0, '0, '0);
      @(posedge clk);
      @(negedge clk);
      m_ov = 0; m_src = 0; m_data = '0; m_owner = 0; m_run = 0;
      acc0 = 0; acc1 = 0; ntx = 0;
      for (int c = 0; c < 600; c++) begin
         syn_rst = ($urandom_range(0, 63) == 0);
         if (!(in0_valid && !acc0 && $urandom_range(0, 7) != 0)) begin
            in0_valid = 1'($urandom_range(0, 1));
            in0_a = {$urandom, $urandom};
            in0_b = {$urandom, $urandom};
         end
         if (!(in1_valid && !acc1 && $urandom_range(0, 7) != 0)) begin
            in1_valid = 1'($urandom_range(0, 1));
            in1_a = {$urandom, $urandom};
            in1_b = {$urandom, $urandom};
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = -1;
         if (!syn_rst && (!m_ov || out_ready)) begin
            if (in0_valid && in1_valid) g = m_owner;
            else if (in0_valid)         g = 0;
            else if (in1_valid)         g = 1;
         end
         chk("rnd in0_ready", DW'(in0_ready), DW'(g == 0));
         chk("rnd in1_ready", DW'(in1_ready), DW'(g == 1));
         acc0 = (g == 0);
         acc1 = (g == 1);
         if (syn_rst) begin
            m_ov = 0; m_src = 0; m_data = '0; m_owner = 0; m_run = 0;
         end else if (g >= 0) begin
            m_ov   = 1;
            m_src  = (g == 1);
            m_data = (g == 1) ? share_xor(in1_a, in1_b) : share_xor(in0_a, in0_b);
            if (g == m_owner) begin
               m_run++;
               if (m_run >= BURST) begin
                  if ((g == 1) ? in0_valid : in1_valid) begin
                     m_owner = 1 - m_owner;
                     m_run   = 0;
                  end else begin
                     m_run = BURST - 1;
                  end
               end
            end else begin
               m_owner = g;
               m_run   = 1;
            end
         end else if (out_ready) begin
            m_ov = 0;
            if (CLR) m_data = '0;
         end
         @(posedge clk);
         #1;
         chk("rnd out_valid", DW'(out_valid), DW'(m_ov));
         chk("rnd out_src", DW'(out_src), DW'(m_src));
         chk("rnd out_data", out_data, m_data);
         if (g >= 0) begin
            ntx++;
            $display("rnd tx %0d cycle %0d: src=%0d data=%h", ntx, c, g, out_data);
         end
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
